// File: rtl/scurve_data_packer_if.sv
// Handshake and FIFO-write bundle between the S-curve controller, the packer and SCurve_Data_FIFO.
// The slave modport is the packer's view of the bundle; the master modport is the controller/FIFO side.
`timescale 1ns/1ps
interface scurve_data_packer_if;
    logic        test_start;
    logic        test_done;
    logic        point_valid;
    logic        point_ready;
    logic [5:0]  channel;
    logic [9:0]  dac_code;
    logic [31:0] trig_count;
    logic [15:0] fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic        test_active;
    logic [15:0] word_count;

    modport master (
        output test_start, test_done, point_valid, channel, dac_code, trig_count, fifo_full,
        input  point_ready, fifo_din, fifo_wr_en, test_active, word_count
    );

    modport slave (
        input  test_start, test_done, point_valid, channel, dac_code, trig_count, fifo_full,
        output point_ready, fifo_din, fifo_wr_en, test_active, word_count
    );
endinterface

// File: rtl/scurve_data_packer.sv
// Frames S-curve point results as header, three data words per point, tail; 1-cycle accept-to-write latency.
// FIFO writes are gated combinationally by fifo_full; the FSM holds (and fifo_din stays stable) while full.
`timescale 1ns/1ps
module scurve_data_packer #(
    parameter logic [15:0] HEADER_WORD = 16'h5343,
    parameter logic [15:0] TAIL_WORD   = 16'h4E44
) (
    input  logic                  clk,
    input  logic                  rst,
    scurve_data_packer_if.slave   pk
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        WAIT_PT = 3'd2,
        W0      = 3'd3,
        W1      = 3'd4,
        W2      = 3'd5,
        TAIL    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  channel_q, channel_d;
    logic [9:0]  dac_code_q, dac_code_d;
    logic [31:0] trig_count_q, trig_count_d;
    logic        done_pending_q, done_pending_d;
    logic [15:0] word_count_q, word_count_d;

    logic        wr_en;
    logic [15:0] din;
    logic        ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            channel_q      <= '0;
            dac_code_q     <= '0;
            trig_count_q   <= '0;
            done_pending_q <= 1'b0;
            word_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            channel_q      <= channel_d;
            dac_code_q     <= dac_code_d;
            trig_count_q   <= trig_count_d;
            done_pending_q <= done_pending_d;
            word_count_q   <= word_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        channel_d      = channel_q;
        dac_code_d     = dac_code_q;
        trig_count_d   = trig_count_q;
        done_pending_d = done_pending_q;
        word_count_d   = word_count_q;
        wr_en          = 1'b0;
        din            = '0;
        ready          = 1'b0;

        case (state_q)
            IDLE: begin
                if (pk.test_start) begin
                    state_d      = HDR;
                    word_count_d = '0;
                end
            end
            HDR: begin
                din   = HEADER_WORD;
                wr_en = !pk.fifo_full;
                if (pk.test_done) done_pending_d = 1'b1;
                if (wr_en) state_d = WAIT_PT;
            end
            WAIT_PT: begin
                ready = 1'b1;
                if (pk.point_valid) begin
                    channel_d    = pk.channel;
                    dac_code_d   = pk.dac_code;
                    trig_count_d = pk.trig_count;
                    state_d      = W0;
                    if (pk.test_done) done_pending_d = 1'b1;
                end else if (pk.test_done || done_pending_q) begin
                    // A done seen during HDR is honoured here rather than waiting for another pulse.
                    state_d = TAIL;
                end
            end
            W0: begin
                din   = {channel_q, dac_code_q};
                wr_en = !pk.fifo_full;
                if (pk.test_done) done_pending_d = 1'b1;
                if (wr_en) state_d = W1;
            end
            W1: begin
                din   = trig_count_q[31:16];
                wr_en = !pk.fifo_full;
                if (pk.test_done) done_pending_d = 1'b1;
                if (wr_en) state_d = W2;
            end
            W2: begin
                din   = trig_count_q[15:0];
                wr_en = !pk.fifo_full;
                if (pk.test_done) done_pending_d = 1'b1;
                if (wr_en) state_d = (done_pending_q || pk.test_done) ? TAIL : WAIT_PT;
            end
            TAIL: begin
                din   = TAIL_WORD;
                wr_en = !pk.fifo_full;
                if (wr_en) begin
                    state_d        = IDLE;
                    done_pending_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) word_count_d = word_count_q + 16'd1;
    end

    assign pk.fifo_wr_en  = wr_en;
    assign pk.fifo_din    = din;
    assign pk.point_ready = ready;
    assign pk.test_active = (state_q != IDLE);
    assign pk.word_count  = word_count_q;

endmodule

// File: tb/tb_scurve_data_packer.sv
// Directed bench for scurve_data_packer: table of single-point frames plus stall, overflow and reset sequences.
`timescale 1ns/1ps
module tb_scurve_data_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #12.5 clk = ~clk;

    scurve_data_packer_if ifc();
    scurve_data_packer dut (.clk(clk), .rst(rst), .pk(ifc));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Written-word log plus a depth-4 FIFO model with a configurable drain rate.
    logic [15:0] log_q[$];
    logic [15:0] fifo_q[$];
    logic [15:0] drained_q[$];
    logic        pend_wr    = 1'b0;
    logic [15:0] pend_din   = '0;
    logic        force_full = 1'b0;
    logic        model_full = 1'b0;
    int          drain_div  = 1;
    int          cyc        = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_din   = '0;

    assign ifc.fifo_full = force_full | model_full;

    always @(negedge clk) begin
        pend_wr  = ifc.fifo_wr_en;
        pend_din = ifc.fifo_din;
        if (ifc.fifo_wr_en) log_q.push_back(ifc.fifo_din);
        if (prev_stall && ifc.test_active && !ifc.point_ready)
            chk("din_hold", 32'(ifc.fifo_din), 32'(prev_din));
        prev_stall = ifc.test_active && !ifc.point_ready && ifc.fifo_full;
        prev_din   = ifc.fifo_din;
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (pend_wr) fifo_q.push_back(pend_din);
        if (fifo_q.size() > 0 && (cyc % drain_div) == 0) drained_q.push_back(fifo_q.pop_front());
        model_full = (fifo_q.size() >= 4);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ifc.point_ready && k < bound);
        if (!ifc.point_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (ifc.test_active && k < bound);
        if (ifc.test_active) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_log(input string nm, input logic [15:0] exp[$]);
        chk({nm, "_nwords"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(nm, (i < log_q.size()) ? 32'(log_q[i]) : 32'hDEAD_0000, 32'(exp[i]));
    endtask

    typedef struct {
        logic [5:0]  ch;
        logic [9:0]  dac;
        logic [31:0] trig;
        int          done_mode;  // 0: with point, 1: during W0, 2: later in WAIT_PT
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    vec_t vt[5];

    task automatic run_frame(input vec_t v);
        logic [15:0] exp[$];
        log_q.delete();
        ifc.test_start = 1'b1;
        tick();
        ifc.test_start = 1'b0;
        tick();
        ifc.channel     = v.ch;
        ifc.dac_code    = v.dac;
        ifc.trig_count  = v.trig;
        ifc.point_valid = 1'b1;
        ifc.test_done   = (v.done_mode == 0);
        @(negedge clk);
        chk("ready_in_wait", 32'(ifc.point_ready), 32'd1);
        tick();
        ifc.point_valid = 1'b0;
        ifc.test_done   = 1'b0;
        ifc.channel     = ~v.ch;
        ifc.dac_code    = ~v.dac;
        ifc.trig_count  = ~v.trig;
        if (v.done_mode == 1) begin
            ifc.test_done = 1'b1;
            tick();
            ifc.test_done = 1'b0;
        end else if (v.done_mode == 2) begin
            wait_ready(20);
            ifc.test_done = 1'b1;
            tick();
            ifc.test_done = 1'b0;
        end
        wait_idle(40);
        exp = '{16'h5343, v.w0, v.w1, v.w2, 16'h4E44};
        chk_log("frame_word", exp);
        chk("frame_wc", 32'(ifc.word_count), 32'd5);
    endtask

    initial begin
        logic [15:0] exp[$];
        ifc.test_start  = 1'b0;
        ifc.test_done   = 1'b0;
        ifc.point_valid = 1'b0;
        ifc.channel     = '0;
        ifc.dac_code    = '0;
        ifc.trig_count  = '0;

        vt[0] = '{6'd5,  10'h12A, 32'h0001_0003, 0, 16'h152A, 16'h0001, 16'h0003};
        vt[1] = '{6'd63, 10'h3FF, 32'hFFFF_FFFF, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        vt[2] = '{6'd0,  10'h000, 32'h0000_0000, 1, 16'h0000, 16'h0000, 16'h0000};
        vt[3] = '{6'd32, 10'h200, 32'hDEAD_BEEF, 2, 16'h8200, 16'hDEAD, 16'hBEEF};
        vt[4] = '{6'd1,  10'h001, 32'h1234_5678, 1, 16'h0401, 16'h1234, 16'h5678};

        // Reset held with random inputs.
        repeat (4) begin
            @(negedge clk);
            chk("rst_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
            chk("rst_ready", 32'(ifc.point_ready), 32'd0);
            chk("rst_active", 32'(ifc.test_active), 32'd0);
            chk("rst_wc", 32'(ifc.word_count), 32'd0);
            ifc.test_start  = 1'($urandom);
            ifc.test_done   = 1'($urandom);
            ifc.point_valid = 1'($urandom);
            ifc.channel     = 6'($urandom);
            ifc.dac_code    = 10'($urandom);
            ifc.trig_count  = $urandom;
        end
        tick();
        rst = 1'b0;
        ifc.test_start = 1'b0;

        // IDLE ignores points and done.
        ifc.point_valid = 1'b1;
        ifc.test_done   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", 32'(ifc.point_ready), 32'd0);
            chk("idle_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
            chk("idle_active", 32'(ifc.test_active), 32'd0);
        end
        tick();
        ifc.point_valid = 1'b0;
        ifc.test_done   = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(vt[i]);

        // Forced full for 10 cycles in W1, with a stray test_start that must be ignored.
        log_q.delete();
        ifc.test_start = 1'b1;
        tick();
        ifc.test_start = 1'b0;
        tick();
        ifc.channel = 6'd5; ifc.dac_code = 10'h12A; ifc.trig_count = 32'h0001_0003;
        ifc.point_valid = 1'b1;
        tick();
        ifc.point_valid = 1'b0;
        tick();
        force_full = 1'b1;
        ifc.test_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
            chk("stall_din", 32'(ifc.fifo_din), 32'h0001);
            if (i == 0) begin
                tick();
                ifc.test_start = 1'b0;
            end
        end
        @(posedge clk); #1;
        force_full = 1'b0;
        ifc.test_done = 1'b1;
        tick();
        ifc.test_done = 1'b0;
        wait_idle(40);
        exp = '{16'h5343, 16'h152A, 16'h0001, 16'h0003, 16'h4E44};
        chk_log("stall_word", exp);

        // 16 points through the depth-4 FIFO model drained every third cycle.
        @(negedge clk);
        drained_q.delete();
        log_q.delete();
        tick();
        drain_div = 3;
        ifc.test_start = 1'b1;
        tick();
        ifc.test_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ifc.channel     = 6'd0;
            ifc.dac_code    = 10'(i);
            ifc.trig_count  = 32'(i);
            ifc.point_valid = 1'b1;
            wait_ready(200);
            tick();
            ifc.point_valid = 1'b0;
        end
        wait_ready(200);
        ifc.test_done = 1'b1;
        tick();
        ifc.test_done = 1'b0;
        wait_idle(200);
        chk("burst_wc", 32'(ifc.word_count), 32'd50);
        tick();
        drain_div = 1;
        repeat (10) tick();
        exp = '{16'h5343};
        for (int i = 0; i < 16; i++) begin
            exp.push_back(16'(i));
            exp.push_back(16'h0000);
            exp.push_back(16'(i));
        end
        exp.push_back(16'h4E44);
        chk("burst_ndrained", 32'(drained_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk("burst_word", (i < drained_q.size()) ? 32'(drained_q[i]) : 32'hDEAD_0000, 32'(exp[i]));

        // Reset in W1, then a fresh frame with no point.
        ifc.test_start = 1'b1;
        tick();
        ifc.test_start = 1'b0;
        tick();
        ifc.channel = 6'd1; ifc.dac_code = 10'h001; ifc.trig_count = 32'h1234_5678;
        ifc.point_valid = 1'b1;
        tick();
        ifc.point_valid = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_active", 32'(ifc.test_active), 32'd0);
        chk("mid_rst_wr_en", 32'(ifc.fifo_wr_en), 32'd0);
        chk("mid_rst_wc", 32'(ifc.word_count), 32'd0);
        tick();
        rst = 1'b0;
        log_q.delete();
        ifc.test_start = 1'b1;
        tick();
        ifc.test_start = 1'b0;
        @(negedge clk);
        chk("restart_hdr_wr", 32'(ifc.fifo_wr_en), 32'd1);
        chk("restart_hdr_din", 32'(ifc.fifo_din), 32'h5343);
        tick();
        @(negedge clk);
        chk("restart_wc", 32'(ifc.word_count), 32'd1);
        repeat (4) tick();
        chk("restart_no_stale", 32'(log_q.size()), 32'd1);
        ifc.test_done = 1'b1;
        tick();
        ifc.test_done = 1'b0;
        wait_idle(20);
        exp = '{16'h5343, 16'h4E44};
        chk_log("restart_word", exp);
        chk("restart_wc_end", 32'(ifc.word_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
